// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: op encodings, FSM states and op-class helpers.
package ex_pkg;

   localparam int XLEN_DEF = 32;
   localparam int OP_WIDTH = 6;

   typedef logic [OP_WIDTH-1:0] op_t;

   localparam op_t OP_ADD    = 6'd1;
   localparam op_t OP_SUB    = 6'd2;
   localparam op_t OP_AND    = 6'd3;
   localparam op_t OP_OR     = 6'd4;
   localparam op_t OP_XOR    = 6'd5;
   localparam op_t OP_SLL    = 6'd6;
   localparam op_t OP_SRL    = 6'd7;
   localparam op_t OP_SRA    = 6'd8;
   localparam op_t OP_SEQ    = 6'd9;
   localparam op_t OP_SLT    = 6'd10;
   localparam op_t OP_SLTU   = 6'd11;
   localparam op_t OP_LUI    = 6'd12;
   localparam op_t OP_AUIPC  = 6'd13;
   localparam op_t OP_JAL    = 6'd14;
   localparam op_t OP_JALR   = 6'd15;
   localparam op_t OP_LB     = 6'd16;
   localparam op_t OP_LH     = 6'd17;
   localparam op_t OP_LW     = 6'd18;
   localparam op_t OP_LBU    = 6'd19;
   localparam op_t OP_LHU    = 6'd20;
   localparam op_t OP_SB     = 6'd21;
   localparam op_t OP_SH     = 6'd22;
   localparam op_t OP_SW     = 6'd23;
   localparam op_t OP_MUL    = 6'd32;
   localparam op_t OP_MULH   = 6'd33;
   localparam op_t OP_MULHSU = 6'd34;
   localparam op_t OP_MULHU  = 6'd35;
   localparam op_t OP_DIV    = 6'd36;
   localparam op_t OP_DIVU   = 6'd37;
   localparam op_t OP_REM    = 6'd38;
   localparam op_t OP_REMU   = 6'd39;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} ex_state_t;

   function automatic logic is_mul(input op_t op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
   endfunction

   function automatic logic is_div(input op_t op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// ID/EX-to-MEM bus of the execute stage; master is the upstream/controller side, slave is the stage.
interface ex_stage_md_if #(
   parameter int XLEN  = ex_pkg::XLEN_DEF,
   parameter int REG_W = 5,
   parameter int OP_W  = ex_pkg::OP_WIDTH
);
   logic             flush_i;
   logic             valid_i;
   logic [OP_W-1:0]  AluOP;
   logic [XLEN-1:0]  src1;
   logic [XLEN-1:0]  src2;
   logic [XLEN-1:0]  imm_i;
   logic [REG_W-1:0] rd;
   logic             rd_op;
   logic [XLEN-1:0]  link_address_i;
   logic             stallreq;
   logic             valid_o;
   logic [REG_W-1:0] rd_o;
   logic             rd_op_o;
   logic [XLEN-1:0]  rd_data;
   logic [XLEN-1:0]  mem_addr_o;
   logic [XLEN-1:0]  mem_wdata_o;
   logic [OP_W-1:0]  AluOP_o;

   modport master (
      output flush_i, valid_i, AluOP, src1, src2, imm_i, rd, rd_op, link_address_i,
      input  stallreq, valid_o, rd_o, rd_op_o, rd_data, mem_addr_o, mem_wdata_o, AluOP_o
   );

   modport slave (
      input  flush_i, valid_i, AluOP, src1, src2, imm_i, rd, rd_op, link_address_i,
      output stallreq, valid_o, rd_o, rd_op_o, rd_data, mem_addr_o, mem_wdata_o, AluOP_o
   );
endinterface

// File: rtl/ex_div_iter.sv
// Iterative restoring divider on magnitudes, one quotient bit per cycle, XLEN cycles after start.
// done/result are combinational in the final iteration cycle so the caller can register them at that edge.
module ex_div_iter
   import ex_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            kill,
   input  logic            start,
   input  op_t             op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

   logic [XLEN-1:0] quo_q, rem_q, dvsr_q, dvnd_q;
   logic [XLEN-1:0] quo_n, rem_n, q_fix, r_fix, a_mag, b_mag;
   logic [XLEN:0]   trial, diff;
   logic [CW-1:0]   cnt_q;
   logic            sgn, neg_quo_q, neg_rem_q, div0_q, ovf_q, sel_rem_q;

   assign sgn   = (op == OP_DIV) || (op == OP_REM);
   assign a_mag = (sgn && dividend[XLEN-1]) ? -dividend : dividend;
   assign b_mag = (sgn && divisor[XLEN-1])  ? -divisor  : divisor;

   // Borrow out of the trial subtraction decides the quotient bit.
   assign trial = {rem_q, quo_q[XLEN-1]};
   assign diff  = trial - {1'b0, dvsr_q};
   assign rem_n = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
   assign quo_n = {quo_q[XLEN-2:0], ~diff[XLEN]};

   assign done = busy && (cnt_q == LAST);

   always_comb begin
      q_fix = neg_quo_q ? -quo_n : quo_n;
      r_fix = neg_rem_q ? -rem_n : rem_n;
      if (div0_q) begin
         q_fix = '1;
         r_fix = dvnd_q;
      end else if (ovf_q) begin
         q_fix = MIN;
         r_fix = '0;
      end
      result = sel_rem_q ? r_fix : q_fix;
   end

   always_ff @(posedge clk) begin
      if (rst || kill) begin
         busy  <= 1'b0;
         cnt_q <= '0;
      end else if (start) begin
         busy      <= 1'b1;
         cnt_q     <= '0;
         quo_q     <= a_mag;
         rem_q     <= '0;
         dvsr_q    <= b_mag;
         dvnd_q    <= dividend;
         neg_quo_q <= sgn && (dividend[XLEN-1] ^ divisor[XLEN-1]);
         neg_rem_q <= sgn && dividend[XLEN-1];
         div0_q    <= (divisor == '0);
         ovf_q     <= sgn && (dividend == MIN) && (divisor == '1);
         sel_rem_q <= (op == OP_REM) || (op == OP_REMU);
      end else if (busy) begin
         quo_q <= quo_n;
         rem_q <= rem_n;
         cnt_q <= cnt_q + 1'b1;
         if (done) busy <= 1'b0;
      end
   end
endmodule

// File: rtl/ex_stage_md.sv
// RV32 execute stage with folded EX/MEM register; M-extension multiplier/divider/FSM built only
// when EX_MULDIV_EN is defined, otherwise M-class ops take the default (link address) path.
module ex_stage_md
   import ex_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int MUL_LAT = 2,
   parameter int REG_W   = 5,
   parameter int OP_W    = OP_WIDTH
) (
   input logic          CLK,
   input logic          RST,
   ex_stage_md_if.slave bus
);
   localparam int SHW = $clog2(XLEN);

   op_t              op, res_op;
   logic [SHW-1:0]   shamt;
   logic [XLEN-1:0]  alu_res, sum_addr, res_data, res_addr, res_wdata;
   logic [REG_W-1:0] res_rd;
   logic             res_rd_op, wr, clr;

   logic             valid_q, rd_op_q_o;
   logic [REG_W-1:0] rd_q_o;
   logic [XLEN-1:0]  data_q, addr_q, wdata_q;
   logic [OP_W-1:0]  aluop_q;

   assign op       = op_t'(bus.AluOP);
   assign shamt    = bus.src2[SHW-1:0];
   assign sum_addr = bus.src1 + bus.imm_i;

   // LUI expects the shifted immediate in src2; AUIPC expects the pc in src1.
   always_comb begin
      alu_res = bus.link_address_i;
      case (op)
         OP_ADD:   alu_res = bus.src1 + bus.src2;
         OP_SUB:   alu_res = bus.src1 - bus.src2;
         OP_AND:   alu_res = bus.src1 & bus.src2;
         OP_OR:    alu_res = bus.src1 | bus.src2;
         OP_XOR:   alu_res = bus.src1 ^ bus.src2;
         OP_SLL:   alu_res = bus.src1 << shamt;
         OP_SRL:   alu_res = bus.src1 >> shamt;
         OP_SRA:   alu_res = $signed(bus.src1) >>> shamt;
         OP_SEQ:   alu_res = {{(XLEN-1){1'b0}}, bus.src1 == bus.src2};
         OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(bus.src1) < $signed(bus.src2)};
         OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, bus.src1 < bus.src2};
         OP_LUI:   alu_res = bus.src2;
         OP_AUIPC: alu_res = bus.src1 + bus.src2;
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
         OP_SB, OP_SH, OP_SW: alu_res = '0;
         default: ;
      endcase
   end

`ifdef EX_MULDIV_EN
   localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

   ex_state_t        state;
   logic [2:0]       mul_cnt;
   op_t              op_q, mul_sel;
   logic [XLEN-1:0]  a_q, b_q, mul_a, mul_b, mul_res, div_res;
   logic [REG_W-1:0] rd_q;
   logic             rd_op_q, idle, mul_op, div_op, mul_start, div_start;
   logic             mul_last, div_busy, div_done;
   logic signed [XLEN:0] mul_ax, mul_bx;
   logic [2*XLEN-1:0] prod;

   assign idle      = (state == S_IDLE);
   assign mul_op    = is_mul(op);
   assign div_op    = is_div(op);
   assign mul_start = idle && bus.valid_i && !bus.flush_i && mul_op && (MUL_LAT > 1);
   assign div_start = idle && bus.valid_i && !bus.flush_i && div_op;
   assign mul_last  = (state == S_MUL) && (mul_cnt == MUL_LAST);

   // With MUL_LAT==1 the product is taken straight from the bus in the accept cycle.
   assign mul_a   = idle ? bus.src1 : a_q;
   assign mul_b   = idle ? bus.src2 : b_q;
   assign mul_sel = idle ? op : op_q;
   assign mul_ax  = {(mul_sel != OP_MULHU) & mul_a[XLEN-1], mul_a};
   assign mul_bx  = {((mul_sel == OP_MUL) || (mul_sel == OP_MULH)) & mul_b[XLEN-1], mul_b};
   assign prod    = (2*XLEN)'(mul_ax) * (2*XLEN)'(mul_bx);
   assign mul_res = (mul_sel == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

   ex_div_iter #(.XLEN(XLEN)) u_div (
      .clk      (CLK),
      .rst      (RST),
      .kill     (bus.flush_i),
      .start    (div_start),
      .op       (op),
      .dividend (bus.src1),
      .divisor  (bus.src2),
      .busy     (div_busy),
      .done     (div_done),
      .result   (div_res)
   );

   assign bus.stallreq = !RST && !bus.flush_i &&
                         ((idle && bus.valid_i && (div_op || (mul_op && (MUL_LAT > 1)))) ||
                          ((state == S_MUL) && !mul_last) ||
                          (div_busy && !div_done));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         mul_cnt <= '0;
      end else if (bus.flush_i) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (mul_start || div_start) begin
               state   <= mul_start ? S_MUL : S_DIV;
               mul_cnt <= 3'd1;
               op_q    <= op;
               a_q     <= bus.src1;
               b_q     <= bus.src2;
               rd_q    <= bus.rd;
               rd_op_q <= bus.rd_op;
            end
            S_MUL: begin
               mul_cnt <= mul_cnt + 3'd1;
               if (mul_last) state <= S_IDLE;
            end
            S_DIV: if (div_done) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      wr        = 1'b0;
      clr       = bus.flush_i;
      res_data  = alu_res;
      res_rd    = bus.rd;
      res_rd_op = bus.rd_op;
      res_op    = op;
      res_addr  = sum_addr;
      res_wdata = bus.src2;
      if (!bus.flush_i) begin
         if (idle) begin
            clr = !bus.valid_i;
            wr  = bus.valid_i && !mul_start && !div_start;
            if (mul_op) res_data = mul_res;
         end else begin
            wr        = mul_last || ((state == S_DIV) && div_done);
            res_data  = (state == S_MUL) ? mul_res : div_res;
            res_rd    = rd_q;
            res_rd_op = rd_op_q;
            res_op    = op_q;
            res_addr  = addr_q;
            res_wdata = b_q;
         end
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^MUL_LAT;

   assign bus.stallreq = 1'b0;

   always_comb begin
      wr        = bus.valid_i && !bus.flush_i;
      clr       = !wr;
      res_data  = alu_res;
      res_rd    = bus.rd;
      res_rd_op = bus.rd_op;
      res_op    = op;
      res_addr  = sum_addr;
      res_wdata = bus.src2;
   end
`endif

   // Stall cycles leave a bubble; everything except valid_o holds.
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q   <= 1'b0;
         rd_q_o    <= '0;
         rd_op_q_o <= 1'b0;
         data_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         aluop_q   <= '0;
      end else if (wr) begin
         valid_q   <= 1'b1;
         rd_q_o    <= res_rd;
         rd_op_q_o <= res_rd_op;
         data_q    <= res_data;
         addr_q    <= res_addr;
         wdata_q   <= res_wdata;
         aluop_q   <= OP_W'(res_op);
      end else begin
         valid_q <= 1'b0;
         if (clr) rd_op_q_o <= 1'b0;
      end
   end

   assign bus.valid_o     = valid_q;
   assign bus.rd_o        = rd_q_o;
   assign bus.rd_op_o     = rd_op_q_o;
   assign bus.rd_data     = data_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.AluOP_o     = aluop_q;
endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md; expectations switch with EX_MULDIV_EN to match the build.
module tb_ex_stage_md;
   import ex_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   ex_stage_md_if #(.XLEN(32), .REG_W(5), .OP_W(6)) bus ();

   ex_stage_md #(.XLEN(32), .MUL_LAT(2), .REG_W(5), .OP_W(6)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] link,
                        input logic [4:0] rd_i, input logic we);
      bus.valid_i        = 1'b1;
      bus.AluOP          = op;
      bus.src1           = a;
      bus.src2           = b;
      bus.imm_i          = imm;
      bus.link_address_i = link;
      bus.rd             = rd_i;
      bus.rd_op          = we;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.flush_i = 1'b0;
      drive(OP_DIV, 32'd9, 32'd2, 32'd4, 32'h44, 5'd3, 1'b1);
      #1;
      total++; if (bus.stallreq !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stallreq); end
      tick(); tick();
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
      total++; if (bus.rd_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.rd_data); end
      total++; if ({bus.rd_o, bus.rd_op_o, bus.AluOP_o} !== 12'h0) begin bad++; $display("FAIL reset_ctl: got %h want 0", {bus.rd_o, bus.rd_op_o, bus.AluOP_o}); end
      total++; if ({bus.mem_addr_o, bus.mem_wdata_o} !== 64'h0) begin bad++; $display("FAIL reset_mem: got %h want 0", {bus.mem_addr_o, bus.mem_wdata_o}); end
      bus.valid_i = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      drive(OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 5'd3, 1'b1);
      #1;
      total++; if (bus.stallreq !== 1'b0) begin bad++; $display("FAIL b2b_stall0: got %b want 0", bus.stallreq); end
      tick();
      total++; if (bus.valid_o !== 1'b1 || bus.rd_data !== 32'h80000000 || bus.rd_o !== 5'd3) begin
         bad++; $display("FAIL b2b_add: got v=%b d=%h rd=%0d want v=1 d=80000000 rd=3", bus.valid_o, bus.rd_data, bus.rd_o); end
      // upper bits of src2 must be ignored by the shifter
      drive(OP_SRA, 32'h80000000, 32'h00000024, 32'h0, 32'h0, 5'd4, 1'b1);
      #1;
      total++; if (bus.stallreq !== 1'b0) begin bad++; $display("FAIL b2b_stall1: got %b want 0", bus.stallreq); end
      tick();
      total++; if (bus.valid_o !== 1'b1 || bus.rd_data !== 32'hF8000000) begin
         bad++; $display("FAIL b2b_sra: got v=%b d=%h want v=1 d=f8000000", bus.valid_o, bus.rd_data); end
      bus.valid_i = 1'b0;
      tick();
      total++; if (bus.valid_o !== 1'b0 || bus.rd_op_o !== 1'b0 || bus.rd_data !== 32'hF8000000) begin
         bad++; $display("FAIL idle_bubble: got v=%b we=%b d=%h want v=0 we=0 d=f8000000", bus.valid_o, bus.rd_op_o, bus.rd_data); end
   endtask

   task automatic test_alu();
      op_t         ops[12];
      logic [31:0] av[12], bv[12], ev[12];
      ops = '{OP_SUB, OP_SLT, OP_SLTU, OP_SEQ, OP_XOR, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_LUI, OP_AUIPC, OP_JAL};
      av  = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1, 32'h80000000, 32'h55, 32'h1000, 32'h0};
      bv  = '{32'd7, 32'd1, 32'd1, 32'd5, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'd31, 32'd31, 32'h12345000, 32'h2000, 32'h0};
      ev  = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'd1, 32'h0FF00FF0, 32'hF000F000, 32'hFFF0FFF0, 32'h80000000, 32'd1, 32'h12345000, 32'h3000, 32'h2004};
      for (int i = 0; i < 12; i++) begin
         drive(ops[i], av[i], bv[i], 32'h0, 32'h2004, 5'd9, 1'b1);
         tick();
         total++; if (bus.valid_o !== 1'b1 || bus.rd_data !== ev[i] || bus.AluOP_o !== ops[i]) begin
            bad++; $display("FAIL alu_%0d: got v=%b d=%h op=%0d want v=1 d=%h op=%0d", i, bus.valid_o, bus.rd_data, bus.AluOP_o, ev[i], ops[i]); end
      end
      bus.valid_i = 1'b0;
      tick();
   endtask

   task automatic test_mul();
      drive(OP_MULH, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h1234, 5'd5, 1'b1);
      #1;
`ifdef EX_MULDIV_EN
      total++; if (bus.stallreq !== 1'b1) begin bad++; $display("FAIL mul_stall_c0: got %b want 1", bus.stallreq); end
      tick();
      total++; if (bus.stallreq !== 1'b0 || bus.valid_o !== 1'b0) begin
         bad++; $display("FAIL mul_c1: got stall=%b v=%b want stall=0 v=0", bus.stallreq, bus.valid_o); end
      tick();
      total++; if (bus.valid_o !== 1'b1 || bus.rd_data !== 32'hFFFFFFFF) begin
         bad++; $display("FAIL mulh: got v=%b d=%h want v=1 d=ffffffff", bus.valid_o, bus.rd_data); end
      drive(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1234, 5'd5, 1'b1);
      tick(); tick();
      total++; if (bus.valid_o !== 1'b1 || bus.rd_data !== 32'hFFFFFFFE) begin
         bad++; $display("FAIL mulhu: got v=%b d=%h want v=1 d=fffffffe", bus.valid_o, bus.rd_data); end
`else
      total++; if (bus.stallreq !== 1'b0) begin bad++; $display("FAIL mul_stall_c0: got %b want 0", bus.stallreq); end
      tick();
      total++; if (bus.valid_o !== 1'b1 || bus.rd_data !== 32'h1234) begin
         bad++; $display("FAIL mulh_default: got v=%b d=%h want v=1 d=1234", bus.valid_o, bus.rd_data); end
`endif
      bus.valid_i = 1'b0;
      tick();
   endtask

   task automatic test_div();
      op_t         ops[4];
      logic [31:0] av[4], bv[4], ev[4];
      int          stalls, want_stalls;
      ops = '{OP_DIV, OP_REM, OP_DIVU, OP_REM};
      av  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'h80000000};
      bv  = '{32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
`ifdef EX_MULDIV_EN
      ev  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      want_stalls = 32;
`else
      ev  = '{32'h0BAD, 32'h0BAD, 32'h0BAD, 32'h0BAD};
      want_stalls = 0;
`endif
      for (int i = 0; i < 4; i++) begin
         drive(ops[i], av[i], bv[i], 32'h0, 32'h0BAD, 5'd6, 1'b1);
         stalls = 0;
         for (int c = 0; c < 100; c++) begin
            #1;
            if (bus.stallreq !== 1'b1) break;
            stalls++;
            tick();
         end
         tick();
         total++; if (stalls != want_stalls) begin bad++; $display("FAIL div_stalls_%0d: got %0d want %0d", i, stalls, want_stalls); end
         total++; if (bus.valid_o !== 1'b1 || bus.rd_data !== ev[i]) begin
            bad++; $display("FAIL div_res_%0d: got v=%b d=%h want v=1 d=%h", i, bus.valid_o, bus.rd_data, ev[i]); end
      end
      bus.valid_i = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      drive(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 5'd2, 1'b1);
      tick();
      drive(OP_DIV, 32'd100, 32'd3, 32'h0, 32'h0, 5'd2, 1'b1);
`ifdef EX_MULDIV_EN
      for (int c = 0; c < 10; c++) tick();
`endif
      bus.flush_i = 1'b1;
      #1;
      total++; if (bus.stallreq !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", bus.stallreq); end
      tick();
      bus.flush_i = 1'b0;
      total++; if (bus.valid_o !== 1'b0 || bus.rd_op_o !== 1'b0) begin
         bad++; $display("FAIL flush_out: got v=%b we=%b want v=0 we=0", bus.valid_o, bus.rd_op_o); end
      drive(OP_ADD, 32'd2, 32'd3, 32'h0, 32'h0, 5'd8, 1'b1);
      #1;
      total++; if (bus.stallreq !== 1'b0) begin bad++; $display("FAIL post_flush_stall: got %b want 0", bus.stallreq); end
      tick();
      total++; if (bus.valid_o !== 1'b1 || bus.rd_data !== 32'd5 || bus.rd_op_o !== 1'b1) begin
         bad++; $display("FAIL post_flush_add: got v=%b d=%h we=%b want v=1 d=5 we=1", bus.valid_o, bus.rd_data, bus.rd_op_o); end
      bus.valid_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_and_store();
      drive(OP_MUL, 32'd3, 32'd4, 32'h10, 32'h77, 5'd7, 1'b1);
      tick();
      rst = 1'b1;
      #1;
      total++; if (bus.stallreq !== 1'b0) begin bad++; $display("FAIL rst_mid_stall: got %b want 0", bus.stallreq); end
      tick();
      total++; if ({bus.valid_o, bus.rd_op_o, bus.rd_o, bus.AluOP_o} !== 13'h0 || bus.rd_data !== 32'h0) begin
         bad++; $display("FAIL rst_mid_ctl: got v=%b we=%b rd=%0d op=%0d d=%h want all 0", bus.valid_o, bus.rd_op_o, bus.rd_o, bus.AluOP_o, bus.rd_data); end
      total++; if (bus.mem_addr_o !== 32'h0 || bus.mem_wdata_o !== 32'h0) begin
         bad++; $display("FAIL rst_mid_mem: got a=%h w=%h want 0 0", bus.mem_addr_o, bus.mem_wdata_o); end
      rst = 1'b0;
      bus.valid_i = 1'b0;
      tick(); tick();
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_stale: got %b want 0", bus.valid_o); end
      drive(OP_SW, 32'h1000, 32'hDEADBEEF, 32'hFFFFFFFC, 32'h99, 5'd0, 1'b0);
      tick();
      total++; if (bus.mem_addr_o !== 32'h00000FFC || bus.mem_wdata_o !== 32'hDEADBEEF) begin
         bad++; $display("FAIL sw_mem: got a=%h w=%h want a=00000ffc w=deadbeef", bus.mem_addr_o, bus.mem_wdata_o); end
      total++; if (bus.valid_o !== 1'b1 || bus.rd_data !== 32'h0) begin
         bad++; $display("FAIL sw_data: got v=%b d=%h want v=1 d=0", bus.valid_o, bus.rd_data); end
      bus.valid_i = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_alu();
      test_mul();
      test_div();
      test_flush();
      test_reset_mid_and_store();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Next-generation RV32 execute stage with the EX/MEM pipeline register folded in.
- Parametrised in data width and adds RV32M support:
  - a configurable-latency multiplier;
  - an iterative radix-2 divider.
- Handles stall and flush handshaking with the pipeline controller.
- Sits between the ID/EX register and the MEM stage; drives `stallreq` to the controller while a multi-cycle op is in flight.

Parameters:
- XLEN, 32, datapath width; must be a power of 2 and ≥8.
- MUL_LAT, 2, multiply latency in cycles (1..4); 1 means single-cycle.
- REG_W, 5, register index width.
- OP_W, 6, ALU op code width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- flush_i  in  1  kill the in-flight op and the output register.
- valid_i  in  1  ID/EX holds a valid op.
- AluOP  in  OP_W  operation code.
- src1, src2  in  XLEN each  operands.
- imm_i  in  XLEN  sign-extended load/store offset.
- rd  in  REG_W  destination register.
- rd_op  in  1  write-enable request.
- link_address_i  in  XLEN  return address for jumps.
- stallreq  out  1  hold the upstream pipeline (combinational).
- valid_o  out  1  registered result valid.
- rd_o  out  REG_W  registered destination.
- rd_op_o  out  1  registered write enable.
- rd_data  out  XLEN  registered result.
- mem_addr_o  out  XLEN  registered load/store address.
- mem_wdata_o  out  XLEN  registered store data (src2).
- AluOP_o  out  OP_W  registered op.

Behaviour:
- Reset: on RST at a rising edge, every registered output goes to 0 and the FSM goes to IDLE. `stallreq` is 0 while RST is high. Reset mid-operation discards partial divide/multiply state.
- Single-cycle ops (LUI, AUIPC, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SEQ, SLT, SLTU):
  - Result is registered at the edge ending the accept cycle; latency 1; `stallreq` = 0.
  - Shift amount is `src2[log2(XLEN)-1:0]`.
- Loads/stores:
  - `mem_addr_o` = `src1 + imm_i` (modulo 2^XLEN).
  - `rd_data` = 0, `mem_wdata_o` = `src2`.
- Default (jumps and unrecognised ops): `rd_data` = `link_address_i`.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL on `valid_i` & MUL-class op & MUL_LAT>1.
  - IDLE → DIV on `valid_i` & DIV-class op.
  - Operands and op are latched on entry.
- stallreq formula: `stallreq` = (IDLE & `valid_i` & multi-cycle op) | (busy & ~last_cycle).
  - In the last busy cycle `stallreq` = 0; the result registers at that edge and the FSM returns to IDLE.
  - The upstream op still present in the last cycle is the one being completed; it is not re-accepted.
- MUL/MULH/MULHSU/MULHU:
  - Full 2·XLEN product with signedness per op.
  - `stallreq` is high for MUL_LAT-1 cycles; the result registers at the edge ending cycle MUL_LAT-1, counting from accept cycle 0.
- DIV/DIVU/REM/REMU:
  - Restoring divider on magnitudes; XLEN iterations run in cycles 1..XLEN.
  - `stallreq` is high in cycles 0..XLEN-1; the result registers at the edge ending cycle XLEN.
  - Sign fix-up: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Divide by zero (still full latency):
  - Quotient = all ones.
  - Remainder = dividend.
- Signed overflow (-2^(XLEN-1) / -1):
  - Quotient = -2^(XLEN-1).
  - Remainder = 0.
- Stall cycles: `valid_o` = 0 (bubble); the other outputs hold.
- flush_i: at the next edge, `valid_o` = 0, `rd_op_o` = 0 and the FSM goes to IDLE. `stallreq` = 0 in a flush cycle. Flush wins over a simultaneous `valid_i` or completion.
- `valid_i` = 0 in IDLE: `valid_o` = 0 and `rd_op_o` = 0 next edge.

Optional Feature:
- Macro: EX_MULDIV_EN.
- Defined: M-extension ops behave as above.
- Undefined:
  - Multiplier, divider and FSM are not built.
  - M-class ops take the default path (`rd_data` = `link_address_i`) with latency 1.
  - `stallreq` is tied to 0.

Decomposition:
- Shared package ex_pkg holds:
  - ALU op encodings, including the M-class codes;
  - XLEN default;
  - FSM state enum;
  - `is_mul` / `is_div` class helper functions.
- One sub-module, ex_div_iter: start/busy/done handshake; holds dividend, divisor and remainder registers plus an iteration counter; implements the sign and corner-case rules.

Test Plan:
- ADD 0x7FFFFFFF + 1, then SRA 0x80000000 >> 4 back to back → `rd_data` 0x80000000 then 0xF8000000; `valid_o` high on consecutive cycles; `stallreq` never high.
- MULH -2 × 3 with MUL_LAT=2 → `stallreq` high for 1 cycle; `rd_data` 0xFFFFFFFF; `valid_o` pulse at cycle 2.
- DIV -7 / 2, then REM -7 / 2 → results 0xFFFFFFFD and 0xFFFFFFFF; `stallreq` high exactly 32 cycles per op.
- DIVU 5 / 0 and REM 0x80000000 / -1 → results 0xFFFFFFFF and 0x00000000.
- flush_i asserted in cycle 10 of a DIV → `valid_o` and `rd_op_o` 0 next edge; `stallreq` 0; a following ADD completes in 1 cycle.
- RST asserted mid-MUL, and SW with `src1`=0x1000, `imm_i`=-4 → all outputs 0 after reset; `mem_addr_o` 0x00000FFC.
